// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: request/response bundle for alu_ctrl_seq.
//   master: controller side (drives request, abort; observes results)
//   slave : alu_ctrl_seq side
// Signals: in_valid/in_ready handshake, ALUop, func, a, b, abort,
//          ALUoperation, out_valid, illegal, busy, prod ({hi,lo}).
interface alu_ctrl_seq_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int FUNC_W = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W-1:0]       ALUop;
  logic [FUNC_W-1:0]     func;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic                  abort;
  logic [3:0]            ALUoperation;
  logic                  out_valid;
  logic                  illegal;
  logic                  busy;
  logic [2*DATA_W-1:0]   prod;

  modport master (
    output in_valid, ALUop, func, a, b, abort,
    input  in_ready, ALUoperation, out_valid, illegal, busy, prod
  );

  modport slave (
    input  in_valid, ALUop, func, a, b, abort,
    output in_ready, ALUoperation, out_valid, illegal, busy, prod
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequential ALU-control decoder with multi-cycle multiply.
// Decodes ALUop/func into a registered 4-bit ALU operation code and runs a
// radix-2 shift-add multiplier (signed via magnitudes + sign fix-up) for
// ALUop 4 (mult) / 6 (multu).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_ctrl_seq_if.slave (handshake, operands, abort, results)
module alu_ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int FUNC_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] acc;       // {upper accumulator, multiplier}
  logic                sign;
  logic [3:0]          op_q;
  logic                ill_q;
  logic [2*DATA_W-1:0] prod_q;

  logic                accept;
  logic [3:0]          dec_op;
  logic                dec_ill, dec_mul, dec_sgn;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] acc_n, prod_fix;
  logic                last;

  assign bus.in_ready     = (state == IDLE) && !bus.abort;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.out_valid    = (state == RESP);
  assign bus.busy         = (state == MUL);
  assign bus.ALUoperation = op_q;
  assign bus.illegal      = ill_q;
  assign bus.prod         = prod_q;
  assign last             = (cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    dec_op  = 4'b0000;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_sgn = 1'b0;
    case (bus.ALUop)
      OP_W'(0): dec_op = 4'b0000;
      OP_W'(1): dec_op = 4'b0111;
      OP_W'(2): dec_op = 4'b1000;
      OP_W'(3): dec_op = 4'b0110;
      OP_W'(4): begin dec_op = 4'b0010; dec_mul = 1'b1; dec_sgn = 1'b1; end
      OP_W'(5): begin
        case (bus.func)
          FUNC_W'(0): dec_op = 4'b0000;
          FUNC_W'(1): dec_op = 4'b0001;
          FUNC_W'(2): dec_op = 4'b0011;
          FUNC_W'(3): dec_op = 4'b0100;
          FUNC_W'(4): dec_op = 4'b0101;
          FUNC_W'(5): dec_op = 4'b0110;
          FUNC_W'(6): dec_op = 4'b1001;
          default:    dec_ill = 1'b1;
        endcase
      end
      OP_W'(6): begin dec_op = 4'b0010; dec_mul = 1'b1; end
      default:  dec_ill = 1'b1;
    endcase
  end

  // Magnitudes are treated as unsigned, so the most-negative operand
  // negates to itself and still reads as 2^(DATA_W-1).
  always_comb begin
    mag_a = bus.a;
    mag_b = bus.b;
    if (dec_sgn && bus.a[DATA_W-1]) mag_a = (~bus.a) + DATA_W'(1);
    if (dec_sgn && bus.b[DATA_W-1]) mag_b = (~bus.b) + DATA_W'(1);
  end

  // One shift-add step; the carry out of the add becomes the new MSB.
  always_comb begin
    sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_n    = {sum, acc[DATA_W-1:1]};
    prod_fix = sign ? (~acc_n) + (2*DATA_W)'(1) : acc_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = dec_mul ? MUL : RESP;
      MUL:     if (bus.abort) state_n = IDLE;
               else if (last) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      sign   <= 1'b0;
      op_q   <= '0;
      ill_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q  <= dec_op;
        ill_q <= dec_ill;
        if (dec_mul) begin
          mcand <= mag_a;
          acc   <= {{DATA_W{1'b0}}, mag_b};
          sign  <= dec_sgn && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
          cnt   <= '0;
        end
      end else if (state == MUL && !bus.abort) begin
        acc <= acc_n;
        cnt <= cnt + CNT_W'(1);
        if (last) prod_q <= prod_fix;
      end
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Parametrised, sequential successor to the MIPS datapath's combinational ALU-control decoder.
- Decodes ALUop/func into the 4-bit ALU operation code, with a valid/ready handshake.
- Also sequences multi-cycle multiply, signed and unsigned, with an internal radix-2 shift-add engine that drives a 2*DATA_W product.
- Flags illegal encodings and supports a synchronous abort from the controller (pipeline flush / exception).

Parameters:
- DATA_W, 32, operand width; product is 2*DATA_W; multiply takes DATA_W iteration cycles.
- OP_W, 3, width of ALUop.
- FUNC_W, 6, width of func.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept this cycle.
- ALUop  in  OP_W  operation class from main controller.
- func  in  FUNC_W  R-type function field.
- a  in  DATA_W  multiply operand A (multiplicand).
- b  in  DATA_W  multiply operand B (multiplier).
- abort  in  1  synchronous kill of any in-flight request.
- ALUoperation  out  4  registered ALU operation code.
- out_valid  out  1  one-cycle pulse; result fields valid.
- illegal  out  1  qualified by out_valid; encoding undefined.
- busy  out  1  multiply in progress.
- prod  out  2*DATA_W  multiply result, {hi,lo}.

Behaviour:
- Reset (rst_n=0, async): state IDLE; ALUoperation=4'b0000, out_valid=0, illegal=0, busy=0, prod=0.
- States:
  - IDLE: accepts requests.
  - MUL: iterating.
  - RESP: one cycle, drives out_valid.
- in_ready = (state==IDLE) && !abort. A request is accepted on the clk edge where in_valid && in_ready.
- Decode at accept; ALUop values:
  - 0 -> 0000 (lw/sw/addi).
  - 1 -> 0111 (beq).
  - 2 -> 1000 (bne).
  - 3 -> 0110 (slti).
  - 4 -> 0010, signed mult.
  - 5 -> R-type, decoded by func (see below).
  - 6 -> 0010, unsigned multu.
  - 7 -> illegal.
- R-type func values:
  - 0 -> 0000 (add).
  - 1 -> 0001 (sub).
  - 2 -> 0011 (and).
  - 3 -> 0100 (or).
  - 4 -> 0101 (xor).
  - 5 -> 0110 (slt).
  - 6 -> 1001 (nor).
  - Any other func -> illegal.
- Illegal encoding: ALUoperation=0000, illegal=1; takes the single-cycle path.
- Single-cycle ops: IDLE -> RESP on accept. ALUoperation is registered on the accept edge. out_valid=1 for the following cycle, i.e. latency 1. Then RESP -> IDLE.
- Multiply ops (ALUop 4/6):
  - On accept: capture a,b; ALUoperation=0010; busy=1; IDLE -> MUL.
  - Signed: operate on magnitudes; record sign = a[MSB]^b[MSB].
  - MUL runs exactly DATA_W cycles: per cycle, if multiplier LSB is 1, add multiplicand into upper accumulator; then shift right 1 with carry.
  - After the last iteration: MUL -> RESP; the sign fix-up (two's-complement negate of the 2*DATA_W result if sign=1) is applied on that transition.
  - prod and out_valid are valid in RESP. out_valid asserts DATA_W+1 cycles after the accept edge.
  - busy=1 throughout MUL, 0 in RESP and IDLE.
- Holding: ALUoperation, illegal and prod hold their last values outside RESP. prod changes only on multiply completion; single-cycle ops do not alter it.
- Signed edge case: most-negative × most-negative (e.g. 8'h80×8'h80 at DATA_W=8) yields +2^(2*DATA_W-2) = 16'h4000 exactly; magnitude 2^(DATA_W-1) must be handled as unsigned.
- Abort:
  - Any state -> IDLE on the next edge; busy=0; no out_valid for the killed request; prod unchanged.
  - Abort coincident with in_valid: request not accepted.
  - Abort during RESP: the pulse already on the output this cycle stands; state -> IDLE.
- Back-to-back: a new request can be accepted in the cycle after RESP, giving a single-cycle op throughput of 1 per 2 cycles.
- Reset mid-multiply: immediate return to reset values; no residual result.

Test Plan:
- Reset then each legal single-cycle code: ALUop=5, func=6 accepted at edge N -> out_valid at N+1, ALUoperation=1001, illegal=0. ALUop=2 -> 1000.
- Illegal encodings: ALUop=5, func=9 -> ALUoperation=0000, illegal=1 with out_valid. ALUop=7 -> same.
- DATA_W=8, signed: ALUop=4, a=8'hFD (-3), b=8'h05 -> busy high 8 cycles; out_valid 9 cycles after accept; prod=16'hFFF1. Also 8'h80×8'h80 -> 16'h4000.
- DATA_W=8, unsigned: ALUop=6, a=8'hFF, b=8'hFF -> prod=16'hFE01. A following single-cycle op leaves prod=16'hFE01.
- Abort: abort asserted in the 4th MUL cycle -> no out_valid, busy drops next edge, in_ready=1 in the cycle after. Abort with in_valid in IDLE -> in_ready=0, request not accepted.
- Async reset: rst_n low mid-MUL for <1 clk period, between edges -> all outputs at reset values immediately; next request behaves normally.
